mem_port_arbiter: RTL

//  Shares one single-ported, variable-latency memory between the IF stage (instruction

---
 rtl/mem_port_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and load/store.
// Optional one-entry fetch buffer enabled by defining ARB_IFETCH_HOLD_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_BUSY  = 2'd1,
        FETCH_BUSY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              d_act, f_act, timeout_hit;
    logic              buf_hit;
    logic [DATA_W-1:0] buf_data;

`ifdef ARB_IFETCH_HOLD_EN
    logic              buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic [DATA_W-1:0] buf_data_q, buf_data_d;

    assign buf_hit  = buf_vld_q && (if_addr == buf_addr_q);
    assign buf_data = buf_data_q;
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    // A requester whose done pulse is showing has already been served this round.
    assign d_act       = d_req & ~d_done_q;
    assign f_act       = if_req & ~if_done_q;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_done_d    = 1'b0;
        d_rdata_d   = d_rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
`ifdef ARB_IFETCH_HOLD_EN
        buf_vld_d   = buf_vld_q;
        buf_addr_d  = buf_addr_q;
        buf_data_d  = buf_data_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (d_act) begin
                    state_d     = DATA_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    cnt_d       = '0;
                end else if (f_act) begin
                    if (buf_hit) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = buf_data;
                    end else begin
                        state_d     = FETCH_BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        cnt_d       = '0;
                    end
                end
            end

            DATA_BUSY, FETCH_BUSY: begin
                if (mem_ready) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    cnt_d     = '0;
                    if (state_q == DATA_BUSY) begin
                        d_done_d = 1'b1;
                        if (!mem_we_q)
                            d_rdata_d = mem_rdata;
`ifdef ARB_IFETCH_HOLD_EN
                        if (mem_we_q && (mem_addr_q == buf_addr_q))
                            buf_vld_d = 1'b0;
`endif
                    end else begin
                        // A dropped if_req means the fetch was flushed: finish silently.
                        if (if_req) begin
                            if_done_d  = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
`ifdef ARB_IFETCH_HOLD_EN
                        buf_vld_d  = 1'b1;
                        buf_addr_d = mem_addr_q;
                        buf_data_d = mem_rdata;
`endif
                    end
                end else if (timeout_hit) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    cnt_d     = '0;
                    err_d     = 1'b1;
`ifdef ARB_IFETCH_HOLD_EN
                    buf_vld_d = 1'b0;
`endif
                    if (state_q == DATA_BUSY) begin
                        d_done_d  = 1'b1;
                        d_rdata_d = '0;
                    end else if (if_req) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_done_q    <= 1'b0;
            d_rdata_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
`ifdef ARB_IFETCH_HOLD_EN
            buf_vld_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            if_rdata_q  <= if_rdata_d;
            d_done_q    <= d_done_d;
            d_rdata_q   <= d_rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`ifdef ARB_IFETCH_HOLD_EN
            buf_vld_q   <= buf_vld_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign err       = err_q;
    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = d_req & ~d_done_q;

endmodule
